cache_control: RTL and testbench
================================

Name: cache_control

Overview:
- Control FSM for the 2-way set-associative, write-back, write-allocate cache.
- Consumes per-way hit, dirty and LRU status from the cache datapath, whose hit detection gives the left way priority.
- Drives datapath load/select strobes and the physical-memory read/write handshake.
- Returns mem_resp to the CPU-side requester.

Parameters:
- CNT_WIDTH, 32, width of the performance counters. Used only when CACHE_PERF_CNT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_resp  out  1  one-cycle CPU completion pulse
- hit_left  in  1  tag match and valid, left way
- hit_right  in  1  tag match and valid, right way
- dirty_left  in  1  dirty bit of the indexed left line
- dirty_right  in  1  dirty bit of the indexed right line
- lru_out  in  1  LRU way of the indexed set (0=left, 1=right)
- pmem_resp  in  1  physical-memory completion pulse
- pmem_read  out  1  physical-memory line read request
- pmem_write  out  1  physical-memory line write request
- pmem_addr_sel  out  1  0 = CPU address; 1 = victim tag/index (writeback)
- wb_way  out  1  way whose data/tag feeds the writeback
- data_sel  out  1  0 = CPU write data merge; 1 = pmem line fill
- load_data_left, load_data_right  out  1 each  data array write enables
- load_tag_left, load_tag_right  out  1 each  tag write enables
- load_valid_left, load_valid_right  out  1 each  valid write enables (valid_in is always 1)
- load_dirty_left, load_dirty_right  out  1 each  dirty write enables
- dirty_in  out  1  dirty value written
- load_lru  out  1  LRU array write enable
- lru_in  out  1  LRU value written

Behaviour:
- States: IDLE, WRITEBACK, ALLOCATE. A victim_way register holds the way selected on a miss.
- Outputs are combinational decodes of state and inputs. Every output is 0 while rst is high.
- Reset: state goes to IDLE and victim_way to 0 on the first clk edge with rst high.
- Reset mid-operation abandons the miss. pmem_read/pmem_write drop in the rst cycle. No mem_resp is issued.
- A request is active when mem_read or mem_write is high. If both are high, the request is handled as a write.
- IDLE with no request: all outputs 0; stay in IDLE. pmem_resp is ignored.
- IDLE with a request and a hit (hit_left or hit_right): completes in 0 extra cycles.
  - mem_resp=1 in the same cycle.
  - hit_left takes priority if both hit signals are high.
  - load_lru=1; lru_in = the way not hit.
  - On a write: load_data_<way>=1, load_dirty_<way>=1, dirty_in=1, data_sel=0.
  - Stay in IDLE.
- IDLE with a request and a miss:
  - victim_way <= lru_out.
  - Next state is WRITEBACK if dirty_<lru_out>=1, else ALLOCATE.
  - mem_resp=0.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1, wb_way=victim_way.
  - Hold until pmem_resp, then go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_addr_sel=0.
  - On pmem_resp, in that same cycle: data_sel=1; load_data, load_tag, load_valid and load_dirty of victim_way = 1; dirty_in=0. Next state IDLE.
- After a fill, IDLE re-evaluates the request, which now hits.
  - Clean miss: mem_resp 1 cycle after the fill pmem_resp.
  - Dirty miss: same, after both pmem transactions.
- If the request drops during a miss, the fill still completes. mem_resp is not issued unless the request is present in IDLE.
- pmem_read and pmem_write are never high together.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- With the macro defined, three extra outputs exist: hit_count, miss_count, wb_count, each CNT_WIDTH bits.
  - hit_count increments on each IDLE hit with mem_resp.
  - miss_count increments on each IDLE miss.
  - wb_count increments on each WRITEBACK pmem_resp.
  - All counters saturate at all-ones and reset to 0.
- Without the macro, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package cache_types:
  - enum cache_state_t {IDLE, WRITEBACK, ALLOCATE}
  - way_t (1 bit), with constants WAY_LEFT=0, WAY_RIGHT=1
  - constants DATA_SEL_CPU=0, DATA_SEL_PMEM=1
- One sub-module, cache_perf_counter: a saturating CNT_WIDTH counter with inc input, instanced three times under CACHE_PERF_CNT_EN.

Test Plan:
- Read hit, left: mem_read=1, hit_left=1 -> mem_resp=1 same cycle, load_lru=1, lru_in=1, no pmem activity.
- Write hit, right: mem_write=1, hit_right=1 -> mem_resp=1, load_data_right=load_dirty_right=1, dirty_in=1, data_sel=0, lru_in=0.
- Clean miss: mem_read=1, no hit, lru_out=1, dirty_right=0 -> ALLOCATE.
  - pmem_read held 5 cycles until pmem_resp.
  - Right-way loads asserted with data_sel=1, dirty_in=0.
  - Drive hit_right=1 next -> mem_resp.
- Dirty miss: lru_out=0, dirty_left=1 -> pmem_write, pmem_addr_sel=1, wb_way=0 until pmem_resp.
  - Then pmem_read; fill left way.
  - Change lru_out mid-miss -> fill still targets the left way.
- Reset during WRITEBACK: rst=1 for 1 cycle -> pmem_write=0 that cycle, state IDLE, no mem_resp, counters 0.
- With CACHE_PERF_CNT_EN, CNT_WIDTH=2: 4 hits -> hit_count=3 (saturated); 1 dirty miss -> miss_count=1, wb_count=1.

Source files
------------

// File: rtl/cache_types.sv
// Shared types and constants for the 2-way set-associative cache controller.
package cache_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  typedef logic way_t;

  localparam way_t WAY_LEFT  = 1'b0;
  localparam way_t WAY_RIGHT = 1'b1;

  localparam logic DATA_SEL_CPU  = 1'b0;
  localparam logic DATA_SEL_PMEM = 1'b1;

endpackage

// File: rtl/cache_perf_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module cache_perf_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Held at zero during reset so every controller output reads 0 while rst is high.
  assign count = rst ? '0 : count_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way write-back, write-allocate cache.
// Optional performance counters are enabled with the CACHE_PERF_CNT_EN macro.
module cache_control
  import cache_types::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_read,
  input  logic mem_write,
  output logic mem_resp,
  input  logic hit_left,
  input  logic hit_right,
  input  logic dirty_left,
  input  logic dirty_right,
  input  logic lru_out,
  input  logic pmem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic pmem_addr_sel,
  output logic wb_way,
  output logic data_sel,
  output logic load_data_left,
  output logic load_data_right,
  output logic load_tag_left,
  output logic load_tag_right,
  output logic load_valid_left,
  output logic load_valid_right,
  output logic load_dirty_left,
  output logic load_dirty_right,
  output logic dirty_in,
  output logic load_lru,
  output logic lru_in
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
`endif
);

  if (CNT_WIDTH < 1) begin : g_bad_width
    $error("CNT_WIDTH must be at least 1");
  end

  cache_state_t state_d, state_q;
  way_t         victim_way_d, victim_way_q;
  logic         req, hit;
  way_t         hit_way;

  assign req     = mem_read | mem_write;
  assign hit     = hit_left | hit_right;
  assign hit_way = hit_left ? WAY_LEFT : WAY_RIGHT;

  always_comb begin
    // NOTE: every output and next-state gets a default first so no latch is inferred.
    state_d          = state_q;
    victim_way_d     = victim_way_q;
    mem_resp         = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_addr_sel    = 1'b0;
    wb_way           = WAY_LEFT;
    data_sel         = DATA_SEL_CPU;
    load_data_left   = 1'b0;
    load_data_right  = 1'b0;
    load_tag_left    = 1'b0;
    load_tag_right   = 1'b0;
    load_valid_left  = 1'b0;
    load_valid_right = 1'b0;
    load_dirty_left  = 1'b0;
    load_dirty_right = 1'b0;
    dirty_in         = 1'b0;
    load_lru         = 1'b0;
    lru_in           = 1'b0;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (req && hit) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            lru_in   = ~hit_way;
            if (mem_write) begin
              dirty_in = 1'b1;
              data_sel = DATA_SEL_CPU;
              if (hit_way == WAY_LEFT) begin
                load_data_left  = 1'b1;
                load_dirty_left = 1'b1;
              end else begin
                load_data_right  = 1'b1;
                load_dirty_right = 1'b1;
              end
            end
          end else if (req) begin
            victim_way_d = lru_out;
            state_d      = (lru_out ? dirty_right : dirty_left) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          wb_way        = victim_way_q;
          if (pmem_resp) state_d = ALLOCATE;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            // The line fill lands in the way chosen at miss time, not the live LRU.
            data_sel = DATA_SEL_PMEM;
            dirty_in = 1'b0;
            if (victim_way_q == WAY_LEFT) begin
              load_data_left  = 1'b1;
              load_tag_left   = 1'b1;
              load_valid_left = 1'b1;
              load_dirty_left = 1'b1;
            end else begin
              load_data_right  = 1'b1;
              load_tag_right   = 1'b1;
              load_valid_right = 1'b1;
              load_dirty_right = 1'b1;
            end
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; combinational logic above uses blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      victim_way_q <= WAY_LEFT;
    end else begin
      state_q      <= state_d;
      victim_way_q <= victim_way_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic miss_inc, wb_inc;

  assign miss_inc = !rst && (state_q == IDLE) && req && !hit;
  assign wb_inc   = !rst && (state_q == WRITEBACK) && pmem_resp;

  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk(clk), .rst(rst), .inc(mem_resp), .count(hit_count)
  );
  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk(clk), .rst(rst), .inc(miss_inc), .count(miss_count)
  );
  cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk(clk), .rst(rst), .inc(wb_inc), .count(wb_count)
  );
`endif

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: directed vector table, then random traffic checked
// against a transaction-queue model of the miss handling.
module tb_cache_control;

  localparam int W = 2;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write, hit_left, hit_right, dirty_left, dirty_right;
  logic lru_out, pmem_resp;
  logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, wb_way, data_sel;
  logic load_data_left, load_data_right, load_tag_left, load_tag_right;
  logic load_valid_left, load_valid_right, load_dirty_left, load_dirty_right;
  logic dirty_in, load_lru, lru_in;
`ifdef CACHE_PERF_CNT_EN
  logic [W-1:0] hit_count, miss_count, wb_count;
`endif

  always #5 clk = ~clk;

  cache_control #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .hit_left(hit_left), .hit_right(hit_right),
    .dirty_left(dirty_left), .dirty_right(dirty_right), .lru_out(lru_out),
    .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel), .wb_way(wb_way), .data_sel(data_sel),
    .load_data_left(load_data_left), .load_data_right(load_data_right),
    .load_tag_left(load_tag_left), .load_tag_right(load_tag_right),
    .load_valid_left(load_valid_left), .load_valid_right(load_valid_right),
    .load_dirty_left(load_dirty_left), .load_dirty_right(load_dirty_right),
    .dirty_in(dirty_in), .load_lru(load_lru), .lru_in(lru_in)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  // Input record bit order: rst, rd, wr, hit_l, hit_r, dirty_l, dirty_r, lru, pmem_resp
  typedef logic [8:0] in_t;
  typedef struct {
    in_t         in;
    logic [16:0] exp;
  } vec_t;

  localparam logic [16:0] RESP = 17'h1 << 16, PRD = 17'h1 << 15, PWR = 17'h1 << 14;
  localparam logic [16:0] ASEL = 17'h1 << 13, WBW = 17'h1 << 12, DSEL = 17'h1 << 11;
  localparam logic [16:0] DL = 17'h1 << 10, DR = 17'h1 << 9, TL = 17'h1 << 8, TR = 17'h1 << 7;
  localparam logic [16:0] VL = 17'h1 << 6, VR = 17'h1 << 5, YL = 17'h1 << 4, YR = 17'h1 << 3;
  localparam logic [16:0] DIN = 17'h1 << 2, LLRU = 17'h1 << 1, LIN = 17'h1;
  localparam logic [16:0] FILL_L = DSEL | DL | TL | VL | YL;
  localparam logic [16:0] FILL_R = DSEL | DR | TR | VR | YR;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a miss queues the memory transactions it owes; each
  // pmem_resp retires the oldest one. An empty queue means the controller is free.
  typedef enum {OP_WB, OP_FILL} op_e;
  op_e  ops[$];
  logic m_victim = 1'b0;
  int   m_hits = 0, m_misses = 0, m_wbs = 0;

  function automatic int sat(input int c);
    return (c > (1 << W) - 1) ? (1 << W) - 1 : c;
  endfunction

  function automatic logic [16:0] predict(input in_t i);
    logic [16:0] e;
    logic        r_rst, rd, wr, hl, hr, presp;
    int          way;
    r_rst = i[8]; rd = i[7]; wr = i[6]; hl = i[5]; hr = i[4]; presp = i[0];
    e = '0;
    if (r_rst) return e;
    if (ops.size() == 0) begin
      if ((rd || wr) && (hl || hr)) begin
        way = hl ? 0 : 1;
        e = e | RESP | LLRU | ((way == 0) ? LIN : 17'h0);
        if (wr) e = e | DIN | ((way == 0) ? (DL | YL) : (DR | YR));
      end
    end else if (ops[0] == OP_WB) begin
      e = PWR | ASEL | (m_victim ? WBW : 17'h0);
    end else begin
      e = PRD;
      if (presp) e = e | (m_victim ? FILL_R : FILL_L);
    end
    return e;
  endfunction

  task automatic model_step(input in_t i);
    logic rd, wr, hl, hr, dl, dr, lru, presp;
    rd = i[7]; wr = i[6]; hl = i[5]; hr = i[4]; dl = i[3]; dr = i[2]; lru = i[1]; presp = i[0];
    if (i[8]) begin
      ops.delete();
      m_victim = 1'b0;
      m_hits = 0; m_misses = 0; m_wbs = 0;
    end else if (ops.size() == 0) begin
      if ((rd || wr) && (hl || hr)) m_hits++;
      else if (rd || wr) begin
        m_misses++;
        m_victim = lru;
        if (lru ? dr : dl) ops.push_back(OP_WB);
        ops.push_back(OP_FILL);
      end
    end else if (presp) begin
      if (ops[0] == OP_WB) m_wbs++;
      void'(ops.pop_front());
    end
  endtask

  task automatic apply(input in_t i, input logic has_exp, input logic [16:0] exp, input string name);
    logic [16:0] act;
    @(negedge clk);
    {rst, mem_read, mem_write, hit_left, hit_right, dirty_left, dirty_right, lru_out, pmem_resp} = i;
    #1;
    act = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, wb_way, data_sel,
           load_data_left, load_data_right, load_tag_left, load_tag_right,
           load_valid_left, load_valid_right, load_dirty_left, load_dirty_right,
           dirty_in, load_lru, lru_in};
    check({name, " model"}, 32'(act), 32'(predict(i)));
    if (has_exp) check({name, " vector"}, 32'(act), 32'(exp));
    if (pmem_read && pmem_write) check({name, " pmem exclusive"}, 32'(1), 32'(0));
`ifdef CACHE_PERF_CNT_EN
    check({name, " hit_count"},  32'(hit_count),  i[8] ? 32'(0) : 32'(sat(m_hits)));
    check({name, " miss_count"}, 32'(miss_count), i[8] ? 32'(0) : 32'(sat(m_misses)));
    check({name, " wb_count"},   32'(wb_count),   i[8] ? 32'(0) : 32'(sat(m_wbs)));
`endif
    @(posedge clk);
    model_step(i);
  endtask

  vec_t tbl[$];

  initial begin
    {rst, mem_read, mem_write, hit_left, hit_right, dirty_left, dirty_right, lru_out, pmem_resp} = '0;

    tbl.push_back('{9'b1_1_0_1_0_0_0_0_0, 17'h0});                   // reset gates outputs
    tbl.push_back('{9'b0_1_0_1_0_0_0_0_0, RESP | LLRU | LIN});        // read hit left
    tbl.push_back('{9'b0_0_1_0_1_0_0_0_0, RESP | LLRU | DR | YR | DIN}); // write hit right
    tbl.push_back('{9'b0_1_1_1_0_0_0_0_0, RESP | LLRU | LIN | DL | YL | DIN}); // rd+wr = write
    tbl.push_back('{9'b0_1_0_0_0_1_0_1_0, 17'h0});                   // clean miss, victim right
    for (int k = 0; k < 4; k++) tbl.push_back('{9'b0_1_0_0_0_0_0_1_0, PRD});
    tbl.push_back('{9'b0_1_0_0_0_0_0_1_1, PRD | FILL_R});
    tbl.push_back('{9'b0_1_0_0_1_0_0_0_0, RESP | LLRU});              // resp after fill
    tbl.push_back('{9'b0_0_0_0_0_0_0_0_1, 17'h0});                   // idle ignores pmem_resp
    tbl.push_back('{9'b0_1_0_0_0_1_0_0_0, 17'h0});                   // dirty miss, victim left
    tbl.push_back('{9'b0_1_0_0_0_0_0_1_0, PWR | ASEL});               // lru changes mid-miss
    tbl.push_back('{9'b0_1_0_0_0_0_0_1_1, PWR | ASEL});
    tbl.push_back('{9'b0_1_0_0_0_0_1_1_0, PRD});
    tbl.push_back('{9'b0_1_0_0_0_0_1_1_1, PRD | FILL_L});             // fill still left
    tbl.push_back('{9'b0_1_0_1_0_0_0_0_0, RESP | LLRU | LIN});
    tbl.push_back('{9'b0_0_1_0_0_0_1_1_0, 17'h0});                   // dirty miss, victim right
    tbl.push_back('{9'b0_0_1_0_0_0_1_1_0, PWR | ASEL | WBW});
    tbl.push_back('{9'b1_0_1_0_0_0_1_1_0, 17'h0});                   // reset in writeback
    tbl.push_back('{9'b0_0_0_0_0_0_0_0_1, 17'h0});                   // back in idle
    tbl.push_back('{9'b0_1_0_1_0_0_0_0_0, RESP | LLRU | LIN});
    tbl.push_back('{9'b0_1_0_0_0_0_0_0_0, 17'h0});                   // clean miss, left
    tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, PRD});                     // request dropped
    tbl.push_back('{9'b0_0_0_0_0_0_0_0_1, PRD | FILL_L});             // fill completes anyway
    tbl.push_back('{9'b0_0_0_0_0_0_0_0_0, 17'h0});                   // no resp without request
    tbl.push_back('{9'b0_1_0_1_0_0_0_0_0, RESP | LLRU | LIN});

    foreach (tbl[k]) apply(tbl[k].in, 1'b1, tbl[k].exp, $sformatf("vec%0d", k));

    for (int n = 0; n < 3000; n++) begin
      in_t  r;
      logic [1:0] kind;
      kind  = 2'($urandom_range(0, 3));
      r[8]  = ($urandom_range(0, 63) == 0);
      r[7]  = kind[0];
      r[6]  = kind[1];
      r[5]  = ($urandom_range(0, 2) == 0);
      r[4]  = ($urandom_range(0, 2) == 0);
      r[3]  = 1'($urandom);
      r[2]  = 1'($urandom);
      r[1]  = 1'($urandom);
      r[0]  = ($urandom_range(0, 2) == 0);
      apply(r, 1'b0, 17'h0, $sformatf("rnd%0d", n));
    end

    // Counter saturation: 4 hits, then one dirty miss through writeback and fill.
    apply(9'b1_0_0_0_0_0_0_0_0, 1'b1, 17'h0, "perf rst");
    for (int k = 0; k < 4; k++) apply(9'b0_1_0_0_1_0_0_0_0, 1'b1, RESP | LLRU, "perf hit");
    apply(9'b0_1_0_0_0_1_0_0_0, 1'b1, 17'h0, "perf miss");
    apply(9'b0_1_0_0_0_0_0_0_1, 1'b1, PWR | ASEL, "perf wb");
    apply(9'b0_1_0_0_0_0_0_0_1, 1'b1, PRD | FILL_L, "perf fill");
    apply(9'b0_0_0_0_0_0_0_0_0, 1'b1, 17'h0, "perf idle");
`ifdef CACHE_PERF_CNT_EN
    check("perf hit_count sat", 32'(hit_count), 32'd3);
    check("perf miss_count", 32'(miss_count), 32'd1);
    check("perf wb_count", 32'(wb_count), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
